// File: rtl/tag_free_list_pkg.sv
// Shared types for the physical-tag free list and committed rename map.
package tag_free_list_pkg;

    localparam int NUM_TAGS = 64;
    localparam int TAG_W    = $clog2(NUM_TAGS);
    localparam int NUM_ARCH = 32;
    localparam int REG_W    = $clog2(NUM_ARCH);
    localparam int WIDTH    = 4;
    localparam int SQN_W    = 7;

    typedef logic [TAG_W-1:0] Tag;
    typedef logic [SQN_W-1:0] SqN;
    typedef logic [REG_W-1:0] RegNm;

    typedef struct packed {
        logic valid;
        RegNm nmDst;
        Tag   tagDst;
    } CommitUOp;

    typedef struct packed {
        logic taken;
        SqN   sqN;
    } BranchProv;

    typedef enum logic [1:0] {TS_FREE, TS_SPEC, TS_COMMITTED} TagState_t;

    // True when sequence number a is strictly younger than b (wrap-safe signed difference).
    function automatic logic sqn_younger(SqN a, SqN b);
        SqN diff;
        diff = a - b;
        return !diff[SQN_W-1] && (diff != '0);
    endfunction

endpackage

// File: rtl/tag_free_list_free_tag_picker.sv
// Picks the WIDTH lowest-index set bits of the free mask, in ascending order.
module free_tag_picker
    import tag_free_list_pkg::*;
(
    input  logic [NUM_TAGS-1:0] free_mask,
    output Tag                  tag[WIDTH],
    output logic [WIDTH-1:0]    valid
);

    logic [NUM_TAGS-1:0] remaining;

    // Repeated lowest-set-bit search, removing each pick before the next one.
    always_comb begin
        remaining = free_mask;
        valid     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            tag[i] = '0;
            for (int t = NUM_TAGS - 1; t >= 0; t--) begin
                if (remaining[t]) begin
                    tag[i]   = Tag'(t);
                    valid[i] = 1'b1;
                end
            end
            if (valid[i]) remaining[tag[i]] = 1'b0;
        end
    end

endmodule

// File: rtl/tag_free_list.sv
// Physical-tag allocator and committed rename map.
// Optional feature macro FREE_LIST_CNT_EN: adds OUT_freeCount and a double-free check.
module tag_free_list
    import tag_free_list_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  BranchProv        IN_branch,
    input  logic             IN_mispredFlush,
    input  CommitUOp         IN_comUOp[WIDTH],
    input  logic [WIDTH-1:0] IN_alloc,
    input  SqN               IN_allocSqN[WIDTH],
    output Tag               OUT_tag[WIDTH],
    output logic [WIDTH-1:0] OUT_tagValid,
`ifdef FREE_LIST_CNT_EN
    output logic [TAG_W:0]   OUT_freeCount,
`endif
    output Tag               OUT_comMap[NUM_ARCH]
);

    TagState_t           state_q[NUM_TAGS];
    TagState_t           state_d[NUM_TAGS];
    SqN                  sqn_q[NUM_TAGS];
    SqN                  sqn_d[NUM_TAGS];
    Tag                  com_map_q[NUM_ARCH];
    Tag                  com_map_d[NUM_ARCH];
    logic [NUM_TAGS-1:0] free_mask;
`ifdef FREE_LIST_CNT_EN
    logic                double_free;
    logic [TAG_W:0]      free_cnt_d;
`endif

    // Offers come straight from registered state, so frees show up one cycle later.
    always_comb begin
        for (int t = 0; t < NUM_TAGS; t++) free_mask[t] = (state_q[t] == TS_FREE);
    end

    free_tag_picker u_picker (
        .free_mask (free_mask),
        .tag       (OUT_tag),
        .valid     (OUT_tagValid)
    );

    assign OUT_comMap = com_map_q;

    // Next state: alloc (unless branch), branch reclaim, then commits in port order win last.
    always_comb begin
        state_d   = state_q;
        sqn_d     = sqn_q;
        com_map_d = com_map_q;
`ifdef FREE_LIST_CNT_EN
        double_free = 1'b0;
`endif
        if (!IN_branch.taken) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (IN_alloc[i] && OUT_tagValid[i]) begin
                    state_d[OUT_tag[i]] = TS_SPEC;
                    sqn_d[OUT_tag[i]]   = IN_allocSqN[i];
                end
            end
        end else begin
            for (int t = 0; t < NUM_TAGS; t++) begin
                if (state_q[t] == TS_SPEC && sqn_younger(sqn_q[t], IN_branch.sqN))
                    state_d[t] = TS_FREE;
            end
        end
        if (!IN_mispredFlush) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (IN_comUOp[i].valid && IN_comUOp[i].nmDst != '0) begin
                    state_d[IN_comUOp[i].tagDst] = TS_COMMITTED;
`ifdef FREE_LIST_CNT_EN
                    if (state_d[com_map_d[IN_comUOp[i].nmDst]] == TS_FREE) double_free = 1'b1;
`endif
                    // An earlier same-cycle commit to this reg has already updated the map,
                    // so the intermediate tag is the one released here.
                    state_d[com_map_d[IN_comUOp[i].nmDst]] = TS_FREE;
                    com_map_d[IN_comUOp[i].nmDst]          = IN_comUOp[i].tagDst;
                end
            end
        end
    end

    // Tag state and committed map; reset gives identity map with arch tags committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NUM_TAGS; t++)
                state_q[t] <= (t < NUM_ARCH) ? TS_COMMITTED : TS_FREE;
            for (int r = 0; r < NUM_ARCH; r++)
                com_map_q[r] <= Tag'(r);
        end else begin
            state_q   <= state_d;
            com_map_q <= com_map_d;
        end
    end

    // Sequence numbers are only meaningful while a tag is SPEC, so they need no reset.
    always_ff @(posedge clk) begin
        sqn_q <= sqn_d;
    end

    // Rename may only consume a prefix of valid offers.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < WIDTH; i++) assert (!(IN_alloc[i] && !OUT_tagValid[i]));
        end
    end

`ifdef FREE_LIST_CNT_EN
    // Population count of FREE tags in the next state.
    always_comb begin
        free_cnt_d = '0;
        for (int t = 0; t < NUM_TAGS; t++)
            if (state_d[t] == TS_FREE) free_cnt_d = free_cnt_d + (TAG_W+1)'(1);
    end

    // Registered free count.
    always_ff @(posedge clk) begin
        if (rst) OUT_freeCount <= (TAG_W+1)'(NUM_TAGS - NUM_ARCH);
        else     OUT_freeCount <= free_cnt_d;
    end

    // A committed-map tag being released must not already be FREE.
    always @(posedge clk) begin
        if (!rst) assert (!double_free);
    end
`endif

endmodule
